// File: rtl/quad_enc_pkg.sv
// Shared encodings for the quadrature decoder: resolution modes, Gray states
// and the transition classifier used by the counting logic.
package quad_enc_pkg;

  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  typedef enum logic [1:0] {
    TR_NONE = 2'b00,
    TR_FWD  = 2'b01,
    TR_REV  = 2'b10,
    TR_ILL  = 2'b11
  } trans_t;

  // Forward successor in the Gray cycle 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] gray_succ(input logic [1:0] s);
    case (s)
      ST_00:   return ST_10;
      ST_10:   return ST_11;
      ST_11:   return ST_01;
      default: return ST_00;
    endcase
  endfunction

  function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] nxt);
    if (nxt == prev)                 return TR_NONE;
    else if (nxt == gray_succ(prev)) return TR_FWD;
    else if (prev == gray_succ(nxt)) return TR_REV;
    else                             return TR_ILL;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter: the output
// follows the synchronised input only after FILT_LEN consecutive differing samples.
module quad_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       filt_reg;
  logic [3:0] run_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      filt_reg  <= 1'b0;
      run_reg   <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      if (sync2_reg == filt_reg) begin
        run_reg <= '0;
      end else if (run_reg == RUN_LAST) begin
        filt_reg <= sync2_reg;
        run_reg  <= '0;
      end else begin
        run_reg <= run_reg + 4'd1;
      end
    end
  end

  assign dout = filt_reg;

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder decoder: filtered A/B/Z inputs, x1/x2/x4 counting,
// index latch/clear, preload, illegal-transition and wrap reporting.
module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 3,
  parameter int INDEX_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    z_in,
  input  logic [1:0]              mode,
  input  logic                    clr,
  input  logic                    load,
  input  logic [CNT_W-1:0]        load_val,
  input  logic                    index_clr_en,
  output logic signed [CNT_W-1:0] cnt,
  output logic                    dir,
  output logic                    step,
  output logic [1:0]              cur_state,
  output logic                    err,
  output logic                    wrap,
  output logic signed [CNT_W-1:0] index_latch,
  output logic                    index_seen
);

  localparam int INIT_W = 5;
  // Filters need 2 sync stages plus FILT_LEN samples before they reflect the pins.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILT_LEN + 2);
  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] raw;
  logic [2:0] filt;
  logic [1:0] ab;

  assign raw = {a_in, b_in, z_in};
  assign ab  = filt[2:1];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (raw[gi]),
        .dout (filt[gi])
      );
    end
  endgenerate

  logic signed [CNT_W-1:0] cnt_reg, cnt_next;
  logic signed [CNT_W-1:0] latch_reg, latch_next;
  logic [1:0]              state_reg, state_next;
  logic                    dir_reg, dir_next;
  logic                    step_reg, step_next;
  logic                    err_reg, err_next;
  logic                    wrap_reg, wrap_next;
  logic                    seen_reg, seen_next;
  logic                    z_prev_reg;
  logic                    init_reg, init_next;
  logic [INIT_W-1:0]       init_cnt_reg;

  trans_t trans;
  logic   fwd;
  logic   qualified;
  logic   z_rise;

  always_comb begin
    trans     = decode_trans(state_reg, ab);
    fwd       = (trans == TR_FWD);
    qualified = 1'b0;
    if (!init_reg && (trans == TR_FWD || trans == TR_REV)) begin
      case (mode)
        MODE_X1: qualified = fwd ? (state_reg == ST_00 && ab == ST_10)
                                 : (state_reg == ST_10 && ab == ST_00);
        MODE_X2: qualified = (state_reg[1] != ab[1]);
        MODE_X4: qualified = 1'b1;
        default: qualified = 1'b1;
      endcase
    end
    z_rise = (INDEX_EN != 0) && !init_reg && filt[0] && !z_prev_reg;

    cnt_next   = cnt_reg;
    latch_next = latch_reg;
    state_next = ab;
    step_next  = qualified;
    dir_next   = qualified ? fwd : dir_reg;
    err_next   = err_reg | (!init_reg && trans == TR_ILL);
    wrap_next  = 1'b0;
    seen_next  = seen_reg;
    init_next  = init_reg && (init_cnt_reg != INIT_LAST);

    // Lowest-priority count source first; later overrides win.
    if (qualified) begin
      if (fwd) begin
        cnt_next  = cnt_reg + CNT_ONE;
        wrap_next = (cnt_reg == CNT_MAX);
      end else begin
        cnt_next  = cnt_reg - CNT_ONE;
        wrap_next = (cnt_reg == CNT_MIN);
      end
    end
    if (z_rise) begin
      latch_next = cnt_reg;
      seen_next  = 1'b1;
      if (index_clr_en) begin
        cnt_next  = '0;
        wrap_next = 1'b0;
      end
    end
    if (load) begin
      cnt_next  = load_val;
      wrap_next = 1'b0;
    end
    if (clr) begin
      cnt_next  = '0;
      wrap_next = 1'b0;
      err_next  = 1'b0;
      seen_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      latch_reg    <= '0;
      state_reg    <= ST_00;
      dir_reg      <= 1'b0;
      step_reg     <= 1'b0;
      err_reg      <= 1'b0;
      wrap_reg     <= 1'b0;
      seen_reg     <= 1'b0;
      z_prev_reg   <= 1'b0;
      init_reg     <= 1'b1;
      init_cnt_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      latch_reg    <= latch_next;
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      step_reg     <= step_next;
      err_reg      <= err_next;
      wrap_reg     <= wrap_next;
      seen_reg     <= seen_next;
      z_prev_reg   <= filt[0];
      init_reg     <= init_next;
      if (init_reg) init_cnt_reg <= init_cnt_reg + INIT_W'(1);
    end
  end

  assign cnt         = cnt_reg;
  assign dir         = dir_reg;
  assign step        = step_reg;
  assign cur_state   = state_reg;
  assign err         = err_reg;
  assign wrap        = wrap_reg;
  assign index_latch = latch_reg;
  assign index_seen  = seen_reg;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench for quad_encoder_decoder (CNT_W=8, FILT_LEN=3): expected step
// events are queued as pins are driven and checked when the DUT pulses step.
module tb_quad_encoder_decoder;

  localparam int FILT_LEN = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_in, b_in, z_in;
  logic [1:0]        mode;
  logic              clr, load, index_clr_en;
  logic [7:0]        load_val;
  logic signed [7:0] cnt, index_latch;
  logic              dir, step, err, wrap, index_seen;
  logic [1:0]        cur_state;

  quad_encoder_decoder #(.CNT_W(8), .FILT_LEN(FILT_LEN), .INDEX_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .b_in         (b_in),
    .z_in         (z_in),
    .mode         (mode),
    .clr          (clr),
    .load         (load),
    .load_val     (load_val),
    .index_clr_en (index_clr_en),
    .cnt          (cnt),
    .dir          (dir),
    .step         (step),
    .cur_state    (cur_state),
    .err          (err),
    .wrap         (wrap),
    .index_latch  (index_latch),
    .index_seen   (index_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] cnt;
    logic              dir;
    logic              wrap;
    int                due;
    int                id;
  } exp_t;

  exp_t              exp_q[$];
  int                n_cmp  = 0;
  int                n_bad  = 0;
  int                n_push = 0;
  int                cyc    = 0;
  bit                mon_en = 1'b0;
  logic signed [7:0] model_cnt = 8'sd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every step pulse must match the head of the queue, on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (step === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step", step, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("step %0d cyc=%0d cnt=%0d dir=%0d wrap=%0d", e.id, cyc, cnt, dir, wrap);
          chk($sformatf("step%0d_cnt", e.id), cnt, e.cnt);
          chk($sformatf("step%0d_dir", e.id), dir, e.dir);
          chk($sformatf("step%0d_wrap", e.id), wrap, e.wrap);
          chk($sformatf("step%0d_latency", e.id), cyc, e.due);
        end
      end else begin
        chk("wrap_without_step", wrap, 0);
      end
    end
  end

  // Drive {A,B}, queue the expected step if this change should count, hold 10 clocks.
  task automatic drive(input logic [1:0] ab, input bit qual, input bit fwd, input bit idx_clr);
    exp_t e;
    a_in = ab[1];
    b_in = ab[0];
    if (qual) begin
      e.wrap    = !idx_clr && (fwd ? (model_cnt == 8'sh7f) : (model_cnt == 8'sh80));
      model_cnt = idx_clr ? 8'sd0 : (fwd ? model_cnt + 8'sd1 : model_cnt - 8'sd1);
      e.cnt     = model_cnt;
      e.dir     = fwd;
      e.due     = cyc + FILT_LEN + 3;
      e.id      = n_push;
      n_push++;
      exp_q.push_back(e);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_cnt = 8'sd0;
    $display("clr cyc=%0d cnt=%0d err=%0d", cyc, cnt, err);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    model_cnt = v;
    $display("load cyc=%0d val=%0d cnt=%0d", cyc, $signed(v), cnt);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_state"}, cur_state, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_latch"}, index_latch, 0);
    chk({tag, "_seen"}, index_seen, 0);
  endtask

  initial begin
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; z_in = 1'b0;
    mode = 2'b10; clr = 1'b0; load = 1'b0; load_val = 8'd0; index_clr_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset("reset0");
    mon_en = 1'b1;
    rst = 1'b0;
    repeat (15) @(posedge clk); #1;

    // x4 forward cycle: four counts.
    drive(2'b10, 1, 1, 0);
    drive(2'b11, 1, 1, 0);
    drive(2'b01, 1, 1, 0);
    drive(2'b00, 1, 1, 0);
    chk("x4_fwd_cnt", cnt, 4);
    chk("x4_fwd_dir", dir, 1);
    chk("x4_fwd_err", err, 0);

    // x2 reverse cycle: counts only where A changes.
    pulse_clr();
    chk("clr_cnt", cnt, 0);
    mode = 2'b01;
    drive(2'b01, 0, 0, 0);
    drive(2'b11, 1, 0, 0);
    drive(2'b10, 0, 0, 0);
    drive(2'b00, 1, 0, 0);
    chk("x2_rev_cnt", cnt, -2);
    chk("x2_rev_dir", dir, 0);

    // x1 reverse cycle: counts only on 10->00.
    pulse_clr();
    mode = 2'b00;
    drive(2'b01, 0, 0, 0);
    drive(2'b11, 0, 0, 0);
    drive(2'b10, 0, 0, 0);
    drive(2'b00, 1, 0, 0);
    chk("x1_rev_cnt", cnt, -1);
    chk("x1_rev_dir", dir, 0);

    // 2-clock glitch on A must be rejected.
    pulse_clr();
    mode = 2'b10;
    a_in = 1'b1;
    repeat (2) @(posedge clk); #1;
    a_in = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("glitch_state", cur_state, 2'b00);
    chk("glitch_cnt", cnt, 0);

    // Both bits change together: illegal, sticky err, no count.
    drive(2'b11, 0, 0, 0);
    chk("illegal_err", err, 1);
    chk("illegal_cnt", cnt, 0);
    chk("illegal_state", cur_state, 2'b11);
    drive(2'b01, 1, 1, 0);
    chk("err_sticky", err, 1);
    pulse_clr();
    chk("clr_err", err, 0);
    chk("clr_cnt2", cnt, 0);
    drive(2'b00, 1, 1, 0);

    // Wrap at both extremes.
    pulse_load(8'd127);
    chk("load_cnt", cnt, 127);
    drive(2'b10, 1, 1, 0);
    chk("wrap_fwd_cnt", cnt, -128);
    drive(2'b00, 1, 0, 0);
    chk("wrap_rev_cnt", cnt, 127);

    // Index rising edge with clear, coinciding with a forward step.
    pulse_load(8'd37);
    index_clr_en = 1'b1;
    z_in = 1'b1;
    drive(2'b10, 1, 1, 1);
    chk("index_latch", index_latch, 37);
    chk("index_seen", index_seen, 1);
    chk("index_cnt", cnt, 0);
    z_in = 1'b0;
    index_clr_en = 1'b0;

    // Pins at 11 during reset release: no err, no count.
    a_in = 1'b1; b_in = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset("reset1");
    rst = 1'b0;
    model_cnt = 8'sd0;
    repeat (15) @(posedge clk); #1;
    chk("init11_err", err, 0);
    chk("init11_cnt", cnt, 0);
    chk("init11_state", cur_state, 2'b11);

    // Reset mid-transition discards the pending filter state.
    a_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("reset_mid");
    rst = 1'b0;
    repeat (15) @(posedge clk); #1;
    chk("mid_state", cur_state, 2'b01);
    chk("mid_err", err, 0);
    chk("mid_cnt", cnt, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
- Parametrised quadrature-encoder decoder: successor to the fixed 32-bit single-mode encoder controller.
- Adds input synchronisation and glitch filtering, selectable x1/x2/x4 resolution, index (Z) handling, preload and clear, illegal-transition detection and wrap reporting.
- Sits between the raw encoder pins and the motion/position logic; all outputs are synchronous to clk.

Parameters:
- CNT_W, 32, position counter width (two's complement, 8..64)
- FILT_LEN, 3, consecutive identical synchronised samples required to accept a new level (1..15)
- INDEX_EN, 1, 1 = Z input processed; 0 = Z ignored, index outputs tied to reset values

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_in  in  1  encoder channel A, asynchronous
- b_in  in  1  encoder channel B, asynchronous
- z_in  in  1  encoder index, asynchronous
- mode  in  2  00 = x1, 01 = x2, 10 = x4, 11 = x4 (reserved)
- clr  in  1  synchronous counter clear; also clears err
- load  in  1  load load_val into cnt
- load_val  in  CNT_W  preload value
- index_clr_en  in  1  zero cnt on each index rising edge
- cnt  out  CNT_W  signed position count
- dir  out  1  1 = forward (A leads B), holds last direction
- step  out  1  one-cycle pulse on every counted step
- cur_state  out  2  filtered {A,B}
- err  out  1  sticky illegal-transition flag
- wrap  out  1  one-cycle pulse when cnt wraps at either extreme
- index_latch  out  CNT_W  value of cnt in the cycle of the Z rising edge
- index_seen  out  1  sticky; set on first Z rising edge, cleared by clr

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, dir=0, step=0, cur_state=00, err=0, wrap=0, index_latch=0, index_seen=0, filter counters=0, init flag set.
- Input path, per signal: 2-FF synchroniser, then filter. The filtered output takes a new level only after the synchronised value differs from it for FILT_LEN consecutive clocks. Any reversion within that window restarts the filter count.
- Latency: cnt, step and dir update FILT_LEN+2 edges after the edge that first samples a changed pin level.
- Init: the first filtered sample after reset is loaded into cur_state with no count and no err, so a nonzero pin state at reset is harmless.
- Gray sequence {A,B}, forward: 00→10→11→01→00; reverse is the opposite order. No change = idle.
- A simultaneous change of both bits sets err and produces no count, no step, no dir change. err holds until clr or rst.
- Count qualification (valid transitions only):
  - x4: every transition.
  - x2: transitions where A changes.
  - x1: forward on 00→10 only; reverse on 10→00 only.
- Qualified transition: cnt ±1, step=1 for one cycle, dir=1 (forward) or 0 (reverse). Each qualified transition updates dir, including in x1/x2.
- Arithmetic: modulo 2^CNT_W. Max+1→min or min−1→max gives cnt wrapped and wrap=1 for one cycle.
- Index: on a filtered Z rising edge (when INDEX_EN), index_latch ← cnt value before this cycle's update, and index_seen ← 1. If index_clr_en is also 1, cnt ← 0, which overrides that cycle's step increment; step still pulses.
- cnt priority: rst > clr (cnt=0, err=0, index_seen=0) > load (cnt=load_val) > index clear > step increment.
  - step, dir and err detection still operate in clr/load cycles.
  - wrap is suppressed when the count is overridden.
- rst asserted mid-sequence: all state, including filters, is discarded, and the init rule applies afterwards.
- mode change takes effect on the next qualified transition; no count is generated by the change itself.

Decomposition:
- Package quad_enc_pkg: mode encodings (MODE_X1, MODE_X2, MODE_X4), Gray state constants (ST_00, ST_10, ST_11, ST_01), and a function returning +1/−1/0/illegal from (prev,next).
- Sub-module quad_input_filter (synchroniser + FILT_LEN filter, parameter FILT_LEN): three instances, for A, B and Z.

Test Plan:
1. FILT_LEN=3, x4: reset with pins 00, then one forward cycle 00→10→11→01→00 with each level held 10 clk → cnt=4, dir=1, four step pulses, each FILT_LEN+2=5 edges after its pin change, err=0.
2. Same cycle in reverse in x2 and in x1 → cnt −2 and −1 respectively; dir=0.
3. Glitch: A pulse 2 clk wide with FILT_LEN=3 → cur_state, cnt and step unchanged. Both A and B toggled on the same edge → err=1 and cnt unchanged; clr → err=0, cnt=0.
4. CNT_W=8, load_val=127, one forward x4 step → cnt=−128 with wrap pulse. Reverse step → cnt=127 with wrap pulse.
5. Z rising edge at cnt=37 with index_clr_en=1 coinciding with a forward step → index_latch=37, cnt=0, index_seen=1, step=1.
6. Pins 11 at reset release → no err and no count. rst pulsed mid-sequence → all outputs return to reset values the next cycle.
